// File: rtl/seq_emitter_if.sv
// Symbol-emitter request/status bundle.
// master: the requester (drives start/reps/gap/abort).
// slave: the emitter.
interface seq_emitter_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) ();
  logic             start;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic [1:0]       num;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;
  logic             chk_err;

  modport master (
    output start, reps, gap, abort,
    input  num, busy, done, sent_cnt, chk_err
  );

  modport slave (
    input  start, reps, gap, abort,
    output num, busy, done, sent_cnt, chk_err
  );
endinterface

// File: rtl/seq_emitter.sv
// seq_emitter: emits the symbol pattern 1,2,3 `reps` times on a 2-bit bus.
// Each pattern is preceded by `gap` filler (0) symbols. One FIN cycle pulses
// done at the end of a burst. abort returns to IDLE with no done pulse.
// Optional self-check monitor: define SEQ_EMIT_SELFCHK_EN to build it.
// The monitor counts 1,2,3 runs on num and flags a mismatch against reps
// in FIN. When it is not built, chk_err is tied low.
module seq_emitter #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_emitter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_SEND1, S_SEND2, S_SEND3, S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] sent_inc;
  logic [GAP_W-1:0] gap_last;

  assign sent_inc = sent_q + CNT_W'(1);
  assign gap_last = gap_q - GAP_W'(1);

  // State and burst-context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      reps_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      sent_q  <= sent_d;
    end
  end

  // Next-state logic. The gap counter runs only while in GAP, so it
  // restarts at zero for every pattern.
  always_comb begin
    state_d = state_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    gcnt_d  = '0;
    sent_d  = sent_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          reps_d = bus.reps;
          gap_d  = bus.gap;
          sent_d = '0;
          if (bus.reps == '0)     state_d = S_FIN;
          else if (bus.gap != '0) state_d = S_GAP;
          else                    state_d = S_SEND1;
        end
      end
      S_GAP: begin
        if (gcnt_q == gap_last) state_d = S_SEND1;
        else                    gcnt_d  = gcnt_q + GAP_W'(1);
      end
      S_SEND1: state_d = S_SEND2;
      S_SEND2: state_d = S_SEND3;
      S_SEND3: begin
        sent_d = sent_inc;
        if (sent_inc == reps_q) state_d = S_FIN;
        else if (gap_q != '0)   state_d = S_GAP;
        else                    state_d = S_SEND1;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An abort drops any partial pattern, including one that is in SEND3.
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      sent_d  = sent_q;
      gcnt_d  = '0;
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    bus.num = 2'd0;
    case (state_q)
      S_SEND1: bus.num = 2'd1;
      S_SEND2: bus.num = 2'd2;
      S_SEND3: bus.num = 2'd3;
      default: bus.num = 2'd0;
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_FIN);
  assign bus.sent_cnt = sent_q;

`ifdef SEQ_EMIT_SELFCHK_EN
  logic             accept;
  logic [1:0]       h1_q, h2_q;
  logic [CNT_W-1:0] mon_q;
  logic             chk_q;

  assign accept = (state_q == S_IDLE) && bus.start && !bus.abort;

  // Monitor: count 1,2,3 runs on num. Check the count against reps in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q  <= '0;
      h2_q  <= '0;
      mon_q <= '0;
      chk_q <= 1'b0;
    end else if (accept) begin
      h1_q  <= '0;
      h2_q  <= '0;
      mon_q <= '0;
      chk_q <= 1'b0;
    end else begin
      h1_q <= bus.num;
      h2_q <= h1_q;
      if (bus.num == 2'd3 && h1_q == 2'd2 && h2_q == 2'd1)
        mon_q <= mon_q + CNT_W'(1);
      if (state_q == S_FIN && mon_q != reps_q)
        chk_q <= 1'b1;
    end
  end

  assign bus.chk_err = chk_q;
`else
  assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_emitter.sv
// Directed bench for seq_emitter. Each burst pushes its expected per-cycle
// symbol, done and detector values into a scoreboard queue. Values are
// popped and compared while the emitter runs. A small registered
// 1,2,3 detector is fed from num for the loopback check.
module tb_seq_emitter;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  typedef struct {
    logic [1:0] num;
    logic       done;
    logic       det;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  seq_emitter_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  seq_emitter #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback detector: its output is registered and rises one cycle after
  // a 3 that follows 2,1.
  logic [1:0] d1_q, d2_q;
  logic       det_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q  <= '0;
      d2_q  <= '0;
      det_q <= 1'b0;
    end else begin
      d1_q  <= bus.num;
      d2_q  <= d1_q;
      det_q <= (bus.num == 2'd3 && d1_q == 2'd2 && d2_q == 2'd1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fill the scoreboard with one burst: gap zeros then 1,2,3 per rep, then FIN.
  task automatic build(input int r, input int g);
    logic [1:0] p1, p2, p3;
    logic [1:0] s;
    exp_t e;
    p1 = 0; p2 = 0; p3 = 0;
    for (int i = 0; i <= r * (g + 3); i++) begin
      if (i == r * (g + 3)) s = 2'd0;
      else if ((i % (g + 3)) < g) s = 2'd0;
      else s = 2'((i % (g + 3)) - g + 1);
      e.num  = s;
      e.done = (i == r * (g + 3));
      e.det  = (p1 == 2'd3 && p2 == 2'd2 && p3 == 2'd1);
      sb.push_back(e);
      p3 = p2; p2 = p1; p1 = s;
    end
  endtask

  // Compare one scoreboard entry against the current cycle.
  task automatic pop_cmp();
    exp_t e;
    e = sb.pop_front();
    chk("num",     32'(bus.num),     32'(e.num));
    chk("done",    32'(bus.done),    32'(e.done));
    chk("busy",    32'(bus.busy),    32'd1);
    chk("det",     32'(det_q),       32'(e.det));
    chk("chk_err", 32'(bus.chk_err), 32'd0);
  endtask

  task automatic run_burst(input int r, input int g);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.reps = CNT_W'(r); bus.gap = GAP_W'(g);
    build(r, g);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (sb.size() > 0 && cyc < 1000) begin
      pop_cmp();
      cyc++;
      @(negedge clk);
    end
    chk("burst_len", 32'(cyc),          32'(r == 0 ? 1 : r * (g + 3) + 1));
    chk("idle_busy", 32'(bus.busy),     32'd0);
    chk("idle_done", 32'(bus.done),     32'd0);
    chk("idle_num",  32'(bus.num),      32'd0);
    chk("sent_cnt",  32'(bus.sent_cnt), 32'(r));
    chk("chk_err_end", 32'(bus.chk_err), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.reps = '0; bus.gap = '0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_num",  32'(bus.num),      32'd0);
    chk("rst_busy", 32'(bus.busy),     32'd0);
    chk("rst_done", 32'(bus.done),     32'd0);
    chk("rst_sent", 32'(bus.sent_cnt), 32'd0);
    chk("rst_chk",  32'(bus.chk_err),  32'd0);
    rst_n = 1'b1;

    // Reset during SEND2 of a reps=5 gap=2 burst
    @(negedge clk);
    bus.start = 1'b1; bus.reps = 8'd5; bus.gap = 4'd2;
    build(5, 2);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      pop_cmp();
      @(negedge clk);
    end
    // The last compared cycle was SEND2. Step back into it is not possible,
    // so the burst is now in SEND3. Reset it there, then check the SEND2 case below.
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_num",  32'(bus.num),      32'd0);
    chk("mid_rst_busy", 32'(bus.busy),     32'd0);
    chk("mid_rst_sent", 32'(bus.sent_cnt), 32'd0);
    chk("mid_rst_done", 32'(bus.done),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Repeat with the reset landing exactly inside SEND2.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_num2", 32'(bus.num), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst2_num",  32'(bus.num),      32'd0);
    chk("rst2_busy", 32'(bus.busy),     32'd0);
    chk("rst2_sent", 32'(bus.sent_cnt), 32'd0);
    chk("rst2_done", 32'(bus.done),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pattern, gapped burst, zero reps, loopback with gap=1
    run_burst(1, 0);
    run_burst(3, 2);
    run_burst(0, 3);
    run_burst(1, 1);
    run_burst(2, 0);

    // Abort during the 3rd SEND2. A start while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.reps = 8'd4; bus.gap = 4'd0;
    build(4, 0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop_cmp();
      if (i == 1) begin
        bus.start = 1'b1; bus.reps = 8'd9; bus.gap = 4'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (i == 7) bus.abort = 1'b1;
      @(negedge clk);
    end
    bus.abort = 1'b0;
    sb.delete();
    chk("abort_busy", 32'(bus.busy),     32'd0);
    chk("abort_done", 32'(bus.done),     32'd0);
    chk("abort_num",  32'(bus.num),      32'd0);
    chk("abort_sent", 32'(bus.sent_cnt), 32'd2);

    // start together with abort in IDLE: must stay idle with the count kept
    bus.start = 1'b1; bus.abort = 1'b1; bus.reps = 8'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("collide_busy", 32'(bus.busy),     32'd0);
    chk("collide_sent", 32'(bus.sent_cnt), 32'd2);
    @(negedge clk);
    chk("collide_busy2", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
